// File: rtl/sdr_agc_pkg.sv
// sdr_agc_pkg: shared AGC state encoding, magnitude width and saturating absolute value
package sdr_agc_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, DECIDE, SETTLE} state_e;
  localparam int MAG_W = 11;
  function automatic int sat_abs(input int v, input int w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    return (v < 0) ? ((-v > lim) ? lim : -v) : v;
  endfunction
endpackage

// File: rtl/cic_gain_agc_mag_est.sv
// mag_est: registered max(|i|,|q|) with the most-negative code saturated, one-cycle latency
module mag_est
  import sdr_agc_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] i_i,
  input  logic signed [DATA_W-1:0] q_i,
  output logic [DATA_W-2:0]        mag_o
);
  logic [DATA_W-2:0] mag_q, mag_d;
  int ai, aq;
  // larger of the two saturated magnitudes
  always_comb begin
    ai = sat_abs(int'(i_i), DATA_W);
    aq = sat_abs(int'(q_i), DATA_W);
    mag_d = (DATA_W-1)'((ai > aq) ? ai : aq);
  end
  // one register stage so the magnitude lines up with the registered strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mag_q <= '0;
    else mag_q <= mag_d;
  assign mag_o = mag_q;
endmodule

// File: rtl/cic_gain_agc.sv
// cic_gain_agc: peak-window AGC stepping the CIC gain with hysteresis; overload input enabled by CIC_GAIN_AGC_OVL_EN
module cic_gain_agc
  import sdr_agc_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int GAIN_W     = 8,
  parameter int WIN_LOG2   = 10,
  parameter int SETTLE_SMP = 64,
  parameter int GAIN_MIN   = 0,
  parameter int GAIN_MAX   = 7,
  parameter int GAIN_INIT  = 3,
  parameter int HI_THR     = 1536,
  parameter int LO_THR     = 384
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [GAIN_W-1:0]        manual_gain,
  input  logic                     smp_clk,
  input  logic signed [DATA_W-1:0] i_in,
  input  logic signed [DATA_W-1:0] q_in,
  input  logic                     adc_or,
  output logic [GAIN_W-1:0]        gain,
  output logic                     gain_upd,
  output logic [DATA_W-2:0]        peak,
  output logic [7:0]               ovl_cnt
);
  localparam int MW = DATA_W - 1;
  localparam int SC_W = $clog2(SETTLE_SMP + 1);
  localparam logic [GAIN_W-1:0] G_MIN = GAIN_W'(GAIN_MIN);
  localparam logic [GAIN_W-1:0] G_MAX = GAIN_W'(GAIN_MAX);
  localparam logic [MW-1:0] HI = MW'(HI_THR);
  localparam logic [MW-1:0] LO = MW'(LO_THR);
  localparam logic [SC_W-1:0] SET_LAST = SC_W'(SETTLE_SMP - 1);

  state_e state_q, state_d;
  logic smp_q, smp_prev_q, ev;
  logic [MW-1:0] mag, win_peak_q, win_peak_d, peak_q, peak_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic upd_q, upd_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [SC_W-1:0] set_cnt_q, set_cnt_d;
  logic ovl_w, dn, up, chg;
`ifdef CIC_GAIN_AGC_OVL_EN
  logic ovl_q, ovl_d;
  logic [7:0] ovl_cnt_q, ovl_cnt_d;
  assign ovl_w = ovl_q;
  assign ovl_cnt = ovl_cnt_q;
`else
  logic unused_adc_or;
  assign unused_adc_or = adc_or;
  assign ovl_w = 1'b0;
  assign ovl_cnt = 8'd0;
`endif

  mag_est #(.DATA_W(DATA_W)) u_mag (
    .clk  (clk),
    .rst_n(rst_n),
    .i_i  (i_in),
    .q_i  (q_in),
    .mag_o(mag)
  );

  assign ev = smp_q & ~smp_prev_q;
  assign dn = ((win_peak_q >= HI) || ovl_w) && (gain_q > G_MIN);
  assign up = !dn && (win_peak_q < LO) && (gain_q < G_MAX);
  assign chg = dn | up;

  // state, strobe edge detector and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      smp_q      <= 1'b0;
      smp_prev_q <= 1'b0;
      gain_q     <= GAIN_W'(GAIN_INIT);
      upd_q      <= 1'b0;
      peak_q     <= '0;
      win_peak_q <= '0;
      win_cnt_q  <= '0;
      set_cnt_q  <= '0;
`ifdef CIC_GAIN_AGC_OVL_EN
      ovl_q      <= 1'b0;
      ovl_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      smp_q      <= smp_clk;
      smp_prev_q <= smp_q;
      gain_q     <= gain_d;
      upd_q      <= upd_d;
      peak_q     <= peak_d;
      win_peak_q <= win_peak_d;
      win_cnt_q  <= win_cnt_d;
      set_cnt_q  <= set_cnt_d;
`ifdef CIC_GAIN_AGC_OVL_EN
      ovl_q      <= ovl_d;
      ovl_cnt_q  <= ovl_cnt_d;
`endif
    end

  // next-state: dropping enable overrides everything and returns to manual control
  always_comb begin
    state_d = state_q;
    if (!enable) state_d = IDLE;
    else
      unique case (state_q)
        IDLE:    state_d = MEASURE;
        MEASURE: state_d = (ev && &win_cnt_q) ? DECIDE : MEASURE;
        DECIDE:  state_d = chg ? SETTLE : MEASURE;
        SETTLE:  state_d = (ev && set_cnt_q == SET_LAST) ? MEASURE : SETTLE;
        default: state_d = IDLE;
      endcase
  end

  // datapath: window peak, counters, gain stepping and overload bookkeeping
  always_comb begin
    gain_d     = gain_q;
    upd_d      = 1'b0;
    peak_d     = peak_q;
    win_peak_d = win_peak_q;
    win_cnt_d  = win_cnt_q;
    set_cnt_d  = set_cnt_q;
`ifdef CIC_GAIN_AGC_OVL_EN
    ovl_d      = ovl_q;
    ovl_cnt_d  = ovl_cnt_q;
`endif
    if (!enable || state_q == IDLE) begin
      gain_d     = manual_gain;
      win_peak_d = '0;
      win_cnt_d  = '0;
      set_cnt_d  = '0;
`ifdef CIC_GAIN_AGC_OVL_EN
      ovl_d      = 1'b0;
`endif
    end else if (state_q == MEASURE) begin
      win_peak_d = (ev && mag > win_peak_q) ? mag : win_peak_q;
      win_cnt_d  = ev ? win_cnt_q + 1'b1 : win_cnt_q;
`ifdef CIC_GAIN_AGC_OVL_EN
      ovl_d      = ovl_q | adc_or;
`endif
    end else if (state_q == DECIDE) begin
      peak_d     = win_peak_q;
      gain_d     = dn ? gain_q - 1'b1 : up ? gain_q + 1'b1 : gain_q;
      upd_d      = chg;
      win_peak_d = (ev && !chg) ? mag : '0;
      win_cnt_d  = (ev && !chg) ? WIN_LOG2'(1) : '0;
      set_cnt_d  = (ev && chg) ? SC_W'(1) : '0;
`ifdef CIC_GAIN_AGC_OVL_EN
      ovl_d      = 1'b0;
      ovl_cnt_d  = (ovl_q && ovl_cnt_q != 8'hFF) ? ovl_cnt_q + 1'b1 : ovl_cnt_q;
`endif
    end else if (state_q == SETTLE && ev)
      set_cnt_d = (set_cnt_q == SET_LAST) ? '0 : set_cnt_q + 1'b1;
  end

  assign gain = gain_q;
  assign gain_upd = upd_q;
  assign peak = peak_q;
endmodule

// File: tb/tb_cic_gain_agc.sv
// tb_cic_gain_agc: directed checks of reset, manual gain, stepping, limits, settle, overload and enable drop
module tb_cic_gain_agc;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, smp_clk = 1'b0, adc_or = 1'b0;
  logic [7:0] manual_gain = 8'd5;
  logic signed [11:0] i_in = '0, q_in = '0;
  logic [7:0] gain, ovl_cnt;
  logic gain_upd;
  logic [10:0] peak;
  int n_run = 0, n_fail = 0, upd_cnt = 0, exp_upd = 0, exp_ovl = 0;

  cic_gain_agc #(.WIN_LOG2(4), .SETTLE_SMP(2), .GAIN_INIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .manual_gain(manual_gain),
    .smp_clk(smp_clk), .i_in(i_in), .q_in(q_in), .adc_or(adc_or),
    .gain(gain), .gain_upd(gain_upd), .peak(peak), .ovl_cnt(ovl_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (gain_upd === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ev(input int i, input int q);
    @(negedge clk);
    i_in = 12'(i);
    q_in = 12'(q);
    smp_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    smp_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic window(input int i, input int q);
    repeat (16) ev(i, q);
    repeat (2) @(negedge clk);
  endtask

  task automatic settle();
    repeat (2) ev(2047, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gain", gain, 3);
    chk("rst_upd", gain_upd, 0);
    chk("rst_peak", peak, 0);
    chk("rst_ovl", ovl_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("manual_gain5", gain, 5);
    chk("manual_no_upd", upd_cnt, 0);
    manual_gain = 8'd3;
    @(negedge clk);
    chk("manual_gain3", gain, 3);
    enable = 1'b1;
    @(negedge clk);
    window(1800, 0);
    exp_upd = 1;
    chk("hi_peak", peak, 1800);
    chk("hi_gain", gain, 2);
    chk("hi_upd", upd_cnt, exp_upd);
    settle();
    window(-100, 200);
    exp_upd++;
    chk("lo_peak", peak, 200);
    chk("lo_gain", gain, 3);
    chk("lo_upd", upd_cnt, exp_upd);
    for (int g = 4; g <= 7; g++) begin
      settle();
      window(-100, 200);
      exp_upd++;
      chk("up_step", gain, 32'(g));
    end
    settle();
    window(-100, 200);
    chk("max_hold_gain", gain, 7);
    chk("max_hold_upd", upd_cnt, exp_upd);
    for (int g = 6; g >= 0; g--) begin
      window(-2048, 0);
      exp_upd++;
      chk("dn_step", gain, 32'(g));
      chk("dn_peak_sat", peak, 2047);
      settle();
    end
    window(-2048, 0);
    chk("min_hold_gain", gain, 0);
    chk("min_hold_upd", upd_cnt, exp_upd);
    window(-100, 200);
    exp_upd++;
    chk("min_up_gain", gain, 1);
    settle();
    repeat (8) ev(500, 0);
    @(negedge clk);
    adc_or = 1'b1;
    @(negedge clk);
    adc_or = 1'b0;
    repeat (8) ev(500, 0);
    repeat (2) @(negedge clk);
    chk("ovl_peak", peak, 500);
`ifdef CIC_GAIN_AGC_OVL_EN
    exp_upd++;
    exp_ovl = 1;
    chk("ovl_gain", gain, 0);
    settle();
`else
    chk("ovl_gain", gain, 1);
`endif
    chk("ovl_cnt", ovl_cnt, 32'(exp_ovl));
    chk("ovl_upd", upd_cnt, exp_upd);
    manual_gain = 8'd6;
    repeat (8) ev(2047, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_gain", gain, 6);
    chk("drop_peak", peak, 500);
    chk("drop_upd", upd_cnt, exp_upd);
    enable = 1'b1;
    @(negedge clk);
    window(-100, 200);
    exp_upd++;
    chk("reen_peak", peak, 200);
    chk("reen_gain", gain, 7);
    chk("reen_upd", upd_cnt, exp_upd);
    repeat (4) ev(2047, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_gain", gain, 3);
    chk("arst_peak", peak, 0);
    chk("arst_ovl", ovl_cnt, 0);
    chk("arst_upd", gain_upd, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cic_gain_agc.md
# cic_gain_agc

Automatic gain controller for the CIC decimator stage of the FM receive chain. It watches the decimated I/Q stream (CIC output data plus CIC output strobe) and the ADC over-range flag, measures peak magnitude over a fixed window of decimated samples, and steps the CIC `gain` control up or down with hysteresis. Both CIC instances (I and Q) take their `gain` input from this block; the FM demodulator input level is kept inside the demodulator's usable range.

## Interface
- `DATA_W`, 12: width of signed CIC output samples.
- `GAIN_W`, 8: width of gain word driven to CIC.
- `WIN_LOG2`, 10: measurement window = 2^WIN_LOG2 decimated samples.
- `SETTLE_SMP`, 64: decimated samples discarded after each gain change (CIC flush).
- `GAIN_MIN`, 0 / `GAIN_MAX`, 7 / `GAIN_INIT`, 3: gain limits and reset value; larger gain = larger CIC output.
- `HI_THR`, 1536 / `LO_THR`, 384: unsigned peak thresholds; LO_THR < HI_THR.
- `clk` in 1: system clock (ADC sample clock domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = AGC running, 0 = manual gain.
- `manual_gain` in GAIN_W: gain used while `enable`=0.
- `smp_clk` in 1: CIC output strobe, level signal synchronous to `clk`; a sample is taken on its rising edge.
- `i_in`, `q_in` in DATA_W signed: CIC outputs.
- `adc_or` in 1: ADC over-range.
- `gain` out GAIN_W: gain to both CICs.
- `gain_upd` out 1: one-cycle pulse when AGC changes `gain`.
- `peak` out DATA_W-1: peak of last completed window.
- `ovl_cnt` out 8: saturating count of windows with overload.

## Operation
- Sample event: `smp_clk` registered; event when current=1, previous=0.
- Magnitude: mag = max(|i|,|q|); |−2^(DATA_W−1)| saturates to 2^(DATA_W−1)−1.
- States: IDLE, MEASURE, DECIDE, SETTLE.
- IDLE: `gain` <= `manual_gain` every cycle; counters and window peak cleared. `enable`=1 -> MEASURE.
- MEASURE: per event, win_peak <= max(win_peak, mag), win_cnt++. Event that makes win_cnt reach 2^WIN_LOG2 -> DECIDE (that sample included).
- DECIDE (one cycle): `peak` <= win_peak. If win_peak >= HI_THR (or overload, see Configuration) and gain > GAIN_MIN: gain−1. Else if win_peak < LO_THR and gain < GAIN_MAX: gain+1. Else hold. On change -> SETTLE and pulse `gain_upd`; no change -> MEASURE. win_peak, win_cnt cleared.
- SETTLE: count SETTLE_SMP events, then MEASURE. Events are not measured.
- `enable` falling in any state -> IDLE next cycle, manual gain applied; pending decision dropped.
- `manual_gain` outside [GAIN_MIN,GAIN_MAX] passed through in IDLE; on entry to MEASURE, AGC clamps on first DECIDE only by stepping rules.

## Timing
- Reset: state IDLE, `gain`=GAIN_INIT, `gain_upd`=0, `peak`=0, `ovl_cnt`=0, all counters 0.
- Event detection: 1 cycle after `smp_clk` rises; data sampled same cycle as detection.
- Window end: DECIDE is the cycle after the last counted event; `gain`, `peak`, `gain_upd` valid the following cycle.
- Event coinciding with DECIDE: counted as first SETTLE event if gain changed, else as first sample of new window.
- IDLE -> MEASURE: first event counted is the first detected after entry.
- Mid-operation `rst_n` low: immediate return to reset values; no partial window retained.

## Configuration
- `CIC_GAIN_AGC_OVL_EN` defined: `adc_or` high for any cycle during MEASURE marks window overloaded; DECIDE forces step-down (if gain > GAIN_MIN) regardless of peak; `ovl_cnt` increments (saturating at 255) per overloaded window.
- Undefined: `adc_or` ignored, `ovl_cnt` tied 0, decisions on peak only.

## Structure
- Package `sdr_agc_pkg`: state enum, magnitude width constant, saturating-abs function.
- Sub-module `mag_est`: registered max(|i|,|q|) with saturation, one-cycle latency, instantiated once.

## Test plan
Bench parameters: WIN_LOG2=4, SETTLE_SMP=2, GAIN_INIT=3.
- Reset, `enable`=0, `manual_gain`=5 -> `gain`=5 next cycle, no `gain_upd`.
- `enable`=1, 16 events i=1800,q=0 -> `peak`=1800, `gain`=2, one `gain_upd`; next 2 events ignored.
- 16 events i=−100,q=200 -> `gain` +1, `peak`=200; at GAIN_MAX=7 held, no pulse.
- 16 events i=−2048 -> `peak`=2047, gain −1; at GAIN_MIN held.
- With `CIC_GAIN_AGC_OVL_EN`: mag 500 plus one `adc_or` pulse -> gain −1, `ovl_cnt`=1; without macro -> gain held.
- `enable` dropped at event 8 of window -> IDLE, `gain`=`manual_gain`, `peak` unchanged.
